// File: rtl/collatz_pkg.sv
// Shared types and widths for the Collatz range engine.
// Latency: none (declarations only).
// Backpressure: not applicable.
package collatz_pkg;

  localparam int COUNT_W = 16;
  localparam int VALUE_W = 32;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/collatz_step.sv
// Collatz iterator: value register plus saturating sequence-length counter.
// Latency: load in one cycle, then one Collatz step per cycle until the value is <= 1.
// Backpressure: none; steps run freely, busy tells the owner whether another step follows.
module collatz_step
  import collatz_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [VALUE_W-1:0] value,
  output logic               busy,
  output logic [COUNT_W-1:0] length
);

  logic [VALUE_W-1:0] val_q;
  logic [VALUE_W-1:0] next_val;
  logic [COUNT_W-1:0] cnt_q;
  logic               stepping;

  // Next Collatz value; 3n+1 wraps silently at 32 bits.
  always_comb begin
    next_val = '0;
    if (val_q[0]) begin
      next_val = (val_q << 1) + val_q + VALUE_W'(1);
    end else begin
      next_val = val_q >> 1;
    end
  end

  // Stepping continues while the value is above 1. busy looks one step ahead so the
  // owner can leave its iterate state in the same cycle the final step lands.
  assign stepping = (val_q > VALUE_W'(1));
  assign busy     = stepping && (next_val > VALUE_W'(1));
  assign length   = cnt_q;

  // Value and length registers; a start value of 0 has length 0 by definition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      val_q <= value;
      cnt_q <= (value == '0) ? '0 : COUNT_W'(1);
    end else if (stepping) begin
      val_q <= next_val;
      if (cnt_q != COUNT_MAX) begin
        cnt_q <= cnt_q + COUNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/collatz_range_engine.sv
// Computes Collatz lengths for RAM_WORDS consecutive values from start and stores them in RAM.
// Latency: per value 1 LOAD + (L-1) ITER + 1 WRITE cycles; RAM read data 1 cycle after address.
// Backpressure: none; go is ignored while a run is in progress.
module collatz_range_engine
  import collatz_pkg::*;
#(
  parameter int RAM_WORDS     = 256,
  parameter int RAM_ADDR_BITS = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               go,
  input  logic [31:0]        start,
  output logic               done,
  output logic [COUNT_W-1:0] count
);

  localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_WORDS - 1);

  state_t                   state;
  logic [RAM_ADDR_BITS-1:0] idx;
  logic [VALUE_W-1:0]       base;
  logic [VALUE_W-1:0]       cur_value;
  logic                     step_load;
  logic                     step_busy;
  logic [COUNT_W-1:0]       step_len;
  logic                     ram_we;
  logic [COUNT_W-1:0]       ram [RAM_WORDS];

  assign cur_value = base + VALUE_W'(idx);
  assign step_load = (state == LOAD);
  assign ram_we    = (state == WRITE);

  collatz_step u_step (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (step_load),
    .value   (cur_value),
    .busy    (step_busy),
    .length  (step_len)
  );

  // Run sequencer: walks idx over the range and owns the done flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      base  <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            base  <= start;
            idx   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          state <= (cur_value <= VALUE_W'(1)) ? WRITE : ITER;
        end
        ITER: begin
          if (!step_busy) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          if (idx == LAST_IDX) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            idx   <= idx + 1'b1;
            state <= LOAD;
          end
        end
        DONE: begin
          if (go) begin
            done  <= 1'b0;
            base  <= start;
            idx   <= '0;
            state <= LOAD;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Result RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[idx] <= step_len;
    end
  end

  // Registered read port, active in every state; a same-cycle write returns old data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      count <= ram[start[RAM_ADDR_BITS-1:0]];
    end
  end

endmodule

// File: tb/tb_collatz_range_engine.sv
// Directed bench for collatz_range_engine: run timing, stored lengths, reset and read latency.
// Latency: checks done-rise cycle exactly and 1-cycle read latency.
// Backpressure: exercises go pulses that must be ignored mid-run.
module tb_collatz_range_engine;

  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        go;
  logic [31:0] start;
  logic        done;
  logic [15:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  collatz_range_engine #(
    .RAM_WORDS     (256),
    .RAM_ADDR_BITS (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .go      (go),
    .start   (start),
    .done    (done),
    .count   (count)
  );

  // Reference Collatz length with 32-bit wrap and 16-bit saturation.
  function automatic int clen(input logic [31:0] n);
    logic [31:0] v;
    int          c;
    if (n == 32'd0) return 0;
    v = n;
    c = 1;
    while (v > 32'd1) begin
      v = v[0] ? (v * 32'd3 + 32'd1) : (v >> 1);
      if (c != 65535) c++;
    end
    return c;
  endfunction

  // Expected number of cycles for a full 256-value run.
  function automatic int run_cycles(input logic [31:0] b);
    int          total;
    logic [31:0] n;
    total = 0;
    for (int i = 0; i < 256; i++) begin
      n = b + 32'(i);
      total += (n <= 32'd1) ? 2 : clen(n) + 1;
    end
    return total;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_read(input string tag, input int addr, input int exp);
    @(negedge clk);
    start = 32'(addr);
    @(negedge clk);
    check(tag, {16'd0, count}, 32'(exp));
  endtask

  // Pulse go with start value s, then count cycles until done; optionally pulse go again mid-run.
  task automatic run(input logic [31:0] s, input int pulse_at, output int cyc, output logic done_after_go);
    @(negedge clk);
    start = s;
    go    = 1'b1;
    @(negedge clk);
    go            = 1'b0;
    done_after_go = done;
    cyc           = 0;
    while (done !== 1'b1 && cyc < LIMIT) begin
      if (cyc == pulse_at) begin
        start = 32'd500;
        go    = 1'b1;
      end else begin
        go = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    go = 1'b0;
  endtask

  initial begin
    int   cyc;
    logic d;
    int   addrs [8];

    reset_n = 1'b0;
    go      = 1'b0;
    start   = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_count", {16'd0, count}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Run from 1.
    run(32'd1, -1, cyc, d);
    check("run1_cycles", 32'(cyc), 32'(run_cycles(32'd1)));
    expect_read("run1_addr0", 0, 1);
    expect_read("run1_addr1", 1, 2);
    expect_read("run1_addr2", 2, 8);
    expect_read("run1_addr6", 6, 17);
    expect_read("run1_addr26", 26, 112);

    // Run from 0.
    run(32'd0, -1, cyc, d);
    check("run0_done_drop", {31'd0, d}, 32'd0);
    check("run0_cycles", 32'(cyc), 32'(run_cycles(32'd0)));
    expect_read("run0_addr0", 0, 0);
    expect_read("run0_addr1", 1, 1);

    // Run from 1 with an ignored go (start=500) mid-run.
    run(32'd1, 40, cyc, d);
    check("ignore_cycles", 32'(cyc), 32'(run_cycles(32'd1)));
    expect_read("ignore_addr2", 2, 8);
    expect_read("ignore_addr26", 26, 112);
    expect_read("ignore_addr255", 255, clen(32'd256));

    // Run from 27.
    run(32'd27, -1, cyc, d);
    check("run27_done_drop", {31'd0, d}, 32'd0);
    check("run27_cycles", 32'(cyc), 32'(run_cycles(32'd27)));
    expect_read("run27_addr0", 0, 112);

    // Reset mid-ITER: start=27 keeps reading ram[27] = L(54) = 113 from the previous run.
    @(negedge clk);
    start = 32'd27;
    go    = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_reset_count", {16'd0, count}, 32'd113);
    reset_n = 1'b0;
    #1;
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_count", {16'd0, count}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_done", {31'd0, done}, 32'd0);

    run(32'd1, -1, cyc, d);
    check("rerun_cycles", 32'(cyc), 32'(run_cycles(32'd1)));
    expect_read("rerun_addr6", 6, 17);
    expect_read("rerun_addr100", 100, clen(32'd101));

    // Address stepped every cycle in DONE: count follows one cycle later.
    addrs = '{3, 4, 5, 26, 0, 255, 7, 9};
    @(negedge clk);
    start = 32'(addrs[0]);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check("stream_read", {16'd0, count}, 32'(clen(32'd1 + 32'(addrs[i-1]))));
      start = 32'(addrs[i]);
    end
    @(negedge clk);
    check("stream_last", {16'd0, count}, 32'(clen(32'd1 + 32'(addrs[7]))));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
